// File: rtl/spi_sample_rx_if.sv
// spi_sample_rx_if: serial-side and consumer-side signals of spi_sample_rx.
//   MCU_SS         slave select, active-low
//   MCU_SCK_EN     bit strobe; MCU_MOSI is valid on each edge where it is high
//   MCU_MOSI       serial data, I0, I1, Q0, Q1 per 4-bit sample
//   SAMPLE_READY   consumer accepts the head byte when high with SAMPLE_VALID
//   ERR_CLR        one-cycle pulse clearing the sticky error flags
//   SAMPLE_DATA    FIFO head byte: first sample [7:4], second sample [3:0]
//   SAMPLE_VALID   FIFO non-empty
//   NIBBLE_PENDING first sample of a byte held, awaiting the second
//   OVERFLOW       sticky: completed byte dropped because the FIFO was full
//   FRAME_ERR      sticky: partial sample aborted, or strobe seen with SS high
// master = the side driving the serial link and consumer handshake,
// slave  = the receiver.
interface spi_sample_rx_if;
  logic       MCU_SS;
  logic       MCU_SCK_EN;
  logic       MCU_MOSI;
  logic       SAMPLE_READY;
  logic       ERR_CLR;
  logic [7:0] SAMPLE_DATA;
  logic       SAMPLE_VALID;
  logic       NIBBLE_PENDING;
  logic       OVERFLOW;
  logic       FRAME_ERR;

  modport master (
    output MCU_SS, MCU_SCK_EN, MCU_MOSI, SAMPLE_READY, ERR_CLR,
    input  SAMPLE_DATA, SAMPLE_VALID, NIBBLE_PENDING, OVERFLOW, FRAME_ERR
  );

  modport slave (
    input  MCU_SS, MCU_SCK_EN, MCU_MOSI, SAMPLE_READY, ERR_CLR,
    output SAMPLE_DATA, SAMPLE_VALID, NIBBLE_PENDING, OVERFLOW, FRAME_ERR
  );
endinterface

// File: rtl/spi_sample_rx.sv
// spi_sample_rx: receives 4-bit I/Q samples over a gated serial link, pairs
// them into bytes and queues the bytes in a first-word-fall-through FIFO.
//   MCU_CLK_25_000  sole clock, rising edge
//   RESET           synchronous, active-high
//   bus             spi_sample_rx_if.slave (serial input, consumer handshake,
//                   head byte, status and sticky error flags)
// FIFO_DEPTH must be a power of two, at least 2.
module spi_sample_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             MCU_CLK_25_000,
  input  logic             RESET,
  spi_sample_rx_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Number of bits of the current sample received so far.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StB1   = 2'd1;
  localparam logic [1:0] StB2   = 2'd2;
  localparam logic [1:0] StB3   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [2:0]      shift_q, shift_d;
  logic [3:0]      held_q, held_d;
  logic            pend_q, pend_d;
  logic            wr_vld_q, wr_vld_d;
  logic [7:0]      wr_byte_q, wr_byte_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic       accept;
  logic       frame_set;
  logic [3:0] nibble;
  logic       fifo_valid;
  logic       fifo_full;
  logic       pop;
  logic       do_wr;
  logic       ovf_set;

  assign accept = !bus.MCU_SS && bus.MCU_SCK_EN;
  assign nibble = {shift_q, bus.MCU_MOSI};

  // Bit-level receiver and sample pairing.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    held_d    = held_q;
    pend_d    = pend_q;
    wr_vld_d  = 1'b0;
    wr_byte_d = wr_byte_q;
    // A strobe while deselected is never data.
    frame_set = bus.MCU_SCK_EN && bus.MCU_SS;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = {2'b00, bus.MCU_MOSI};
          state_d = StB1;
        end
      end
      StB1, StB2: begin
        if (accept) begin
          shift_d = {shift_q[1:0], bus.MCU_MOSI};
          state_d = state_q + 2'd1;
        end else begin
          frame_set = 1'b1;
          state_d   = StIdle;
        end
      end
      StB3: begin
        state_d = StIdle;
        if (accept) begin
          if (pend_q) begin
            // Byte goes to the FIFO on the following edge.
            wr_vld_d  = 1'b1;
            wr_byte_d = {held_q, nibble};
            pend_d    = 1'b0;
          end else begin
            held_d = nibble;
            pend_d = 1'b1;
          end
        end else begin
          frame_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO control. A pop frees a slot in the same cycle, so write-when-full
  // with a simultaneous pop succeeds.
  assign fifo_valid = (cnt_q != '0);
  assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop        = fifo_valid && bus.SAMPLE_READY;
  assign do_wr      = wr_vld_q && (!fifo_full || pop);
  assign ovf_set    = wr_vld_q && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_wr && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_wr && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Sticky flags: a new error in the same cycle beats ERR_CLR.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (bus.ERR_CLR) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (ovf_set)   ovf_d  = 1'b1;
    if (frame_set) ferr_d = 1'b1;
  end

  // Output stays at the last shown byte while the FIFO is empty.
  assign bus.SAMPLE_DATA    = fifo_valid ? mem[rd_ptr_q] : hold_q;
  assign hold_d             = bus.SAMPLE_DATA;
  assign bus.SAMPLE_VALID   = fifo_valid;
  assign bus.NIBBLE_PENDING = pend_q;
  assign bus.OVERFLOW       = ovf_q;
  assign bus.FRAME_ERR      = ferr_q;

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      held_q    <= '0;
      pend_q    <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_byte_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      held_q    <= held_d;
      pend_q    <= pend_d;
      wr_vld_q  <= wr_vld_d;
      wr_byte_q <= wr_byte_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      hold_q    <= hold_d;
    end
  end

  // Storage needs no reset; only slots below the occupancy count are read.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET && do_wr) begin
      mem[wr_ptr_q] <= wr_byte_q;
    end
  end

endmodule

// File: tb/tb_spi_sample_rx.sv
module tb_spi_sample_rx;

  logic MCU_CLK_25_000 = 1'b0;
  logic RESET;

  spi_sample_rx_if bus_if ();

  spi_sample_rx #(
    .FIFO_DEPTH(4)
  ) dut (
    .MCU_CLK_25_000(MCU_CLK_25_000),
    .RESET         (RESET),
    .bus           (bus_if)
  );

  always #5 MCU_CLK_25_000 = ~MCU_CLK_25_000;

  typedef struct {
    logic        ss;
    logic        en;
    logic        mosi;
    logic        rdy;
    logic        clr;
    logic [11:0] exp;  // {VALID, PENDING, OVERFLOW, FRAME_ERR, DATA}
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic step();
    @(posedge MCU_CLK_25_000);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {bus_if.SAMPLE_VALID, bus_if.NIBBLE_PENDING, bus_if.OVERFLOW,
            bus_if.FRAME_ERR, bus_if.SAMPLE_DATA};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = obs();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got v/p/o/f/data=%b/%h required %b/%h",
               name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic add(input logic ss, input logic en, input logic mosi, input logic rdy,
                     input logic clr, input logic [3:0] flags, input logic [7:0] data);
    vec_t v;
    v.ss = ss; v.en = en; v.mosi = mosi; v.rdy = rdy; v.clr = clr;
    v.exp = {flags, data};
    vecs.push_back(v);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus_if.MCU_SS = 1'b0; bus_if.MCU_SCK_EN = 1'b1; bus_if.MCU_MOSI = b[i];
      step();
    end
    bus_if.MCU_SCK_EN = 1'b0;
    bus_if.MCU_MOSI   = 1'b0;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    // flags = {VALID, PENDING, OVERFLOW, FRAME_ERR}
    // Byte B6: 1011 then 0110, back to back.
    add(0,1,1,0,0, 4'b0000, 8'h00);
    add(0,1,0,0,0, 4'b0000, 8'h00);
    add(0,1,1,0,0, 4'b0000, 8'h00);
    add(0,1,1,0,0, 4'b0100, 8'h00);
    add(0,1,0,0,0, 4'b0100, 8'h00);
    add(0,1,1,0,0, 4'b0100, 8'h00);
    add(0,1,1,0,0, 4'b0100, 8'h00);
    add(0,1,0,0,0, 4'b0000, 8'h00);  // last bit: not yet visible
    add(0,0,0,0,0, 4'b1000, 8'hB6);  // FIFO write edge
    add(0,0,0,1,0, 4'b0000, 8'hB6);  // pop, data held
    // Aborted partial sample, then byte 12.
    add(0,1,1,0,0, 4'b0000, 8'hB6);
    add(0,1,1,0,0, 4'b0000, 8'hB6);
    add(0,1,1,0,0, 4'b0000, 8'hB6);
    add(0,0,0,0,0, 4'b0001, 8'hB6);
    add(0,1,0,0,0, 4'b0001, 8'hB6);
    add(0,1,0,0,0, 4'b0001, 8'hB6);
    add(0,1,0,0,0, 4'b0001, 8'hB6);
    add(0,1,1,0,0, 4'b0101, 8'hB6);
    add(0,1,0,0,0, 4'b0101, 8'hB6);
    add(0,1,0,0,0, 4'b0101, 8'hB6);
    add(0,1,1,0,0, 4'b0101, 8'hB6);
    add(0,1,0,0,0, 4'b0001, 8'hB6);
    add(0,0,0,0,0, 4'b1001, 8'h12);
    add(0,0,0,1,1, 4'b0000, 8'h12);
    // Sample A, SS high 3 cycles, sample 5: byte A5, no frame error.
    add(0,1,1,0,0, 4'b0000, 8'h12);
    add(0,1,0,0,0, 4'b0000, 8'h12);
    add(0,1,1,0,0, 4'b0000, 8'h12);
    add(0,1,0,0,0, 4'b0100, 8'h12);
    add(1,0,0,0,0, 4'b0100, 8'h12);
    add(1,0,0,0,0, 4'b0100, 8'h12);
    add(1,0,0,0,0, 4'b0100, 8'h12);
    add(0,1,0,0,0, 4'b0100, 8'h12);
    add(0,1,1,0,0, 4'b0100, 8'h12);
    add(0,1,0,0,0, 4'b0100, 8'h12);
    add(0,1,1,0,0, 4'b0000, 8'h12);
    add(0,0,0,0,0, 4'b1000, 8'hA5);
    add(0,0,0,1,0, 4'b0000, 8'hA5);
    // Strobe with SS high: ignored, frame error; then cleared.
    add(1,1,1,0,0, 4'b0001, 8'hA5);
    add(1,0,0,0,1, 4'b0000, 8'hA5);
    // Sample 3 held, partial aborted by SS, held nibble survives -> 3C.
    add(0,1,0,0,0, 4'b0000, 8'hA5);
    add(0,1,0,0,0, 4'b0000, 8'hA5);
    add(0,1,1,0,0, 4'b0000, 8'hA5);
    add(0,1,1,0,0, 4'b0100, 8'hA5);
    add(0,1,1,0,0, 4'b0100, 8'hA5);
    add(0,1,1,0,0, 4'b0100, 8'hA5);
    add(1,0,0,0,0, 4'b0101, 8'hA5);
    add(0,0,0,0,1, 4'b0100, 8'hA5);
    add(0,1,1,0,0, 4'b0100, 8'hA5);
    add(0,1,1,0,0, 4'b0100, 8'hA5);
    add(0,1,0,0,0, 4'b0100, 8'hA5);
    add(0,1,0,0,0, 4'b0000, 8'hA5);
    add(0,0,0,0,0, 4'b1000, 8'h3C);
    add(0,0,0,1,0, 4'b0000, 8'h3C);
    // Set beats clear in the same cycle; pop on empty has no effect.
    add(1,1,0,0,1, 4'b0001, 8'h3C);
    add(1,0,0,0,1, 4'b0000, 8'h3C);
    add(1,0,0,1,0, 4'b0000, 8'h3C);

    RESET = 1'b1;
    bus_if.MCU_SS = 1'b1; bus_if.MCU_SCK_EN = 1'b0; bus_if.MCU_MOSI = 1'b0;
    bus_if.SAMPLE_READY = 1'b0; bus_if.ERR_CLR = 1'b0;
    step();
    step();
    check("reset_state", 12'h000);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      bus_if.MCU_SS       = vecs[i].ss;
      bus_if.MCU_SCK_EN   = vecs[i].en;
      bus_if.MCU_MOSI     = vecs[i].mosi;
      bus_if.SAMPLE_READY = vecs[i].rdy;
      bus_if.ERR_CLR      = vecs[i].clr;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    bus_if.MCU_SS = 1'b0; bus_if.MCU_SCK_EN = 1'b0;
    bus_if.SAMPLE_READY = 1'b0; bus_if.ERR_CLR = 1'b0;

    // Overflow: five bytes into a four-entry FIFO with no consumer.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55);
    step();
    check("ovf_set", {4'b1010, 8'h11});
    bus_if.ERR_CLR = 1'b1; step(); bus_if.ERR_CLR = 1'b0;
    check("ovf_clr", {4'b1000, 8'h11});
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) begin
      check($sformatf("ovf_head%0d", i), {4'b1000, exp_q[i]});
      bus_if.SAMPLE_READY = 1'b1; step(); bus_if.SAMPLE_READY = 1'b0;
    end
    check("ovf_drained", {4'b0000, 8'h44});

    // Full FIFO, pop on the same edge the new byte is written.
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    step();
    check("full_head", {4'b1000, 8'hA1});
    send_byte(8'hA5);
    bus_if.SAMPLE_READY = 1'b1; step(); bus_if.SAMPLE_READY = 1'b0;
    check("full_pop_wr", {4'b1000, 8'hA2});
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    foreach (exp_q[i]) begin
      check($sformatf("full_head%0d", i), {4'b1000, exp_q[i]});
      bus_if.SAMPLE_READY = 1'b1; step(); bus_if.SAMPLE_READY = 1'b0;
    end
    check("full_drained", {4'b0000, 8'hA5});

    // Reset mid-byte with a queued byte and a frame error pending.
    bus_if.MCU_SS = 1'b1; bus_if.MCU_SCK_EN = 1'b1; step();
    bus_if.MCU_SS = 1'b0; bus_if.MCU_SCK_EN = 1'b0;
    send_byte(8'h77);
    step();
    check("pre_rst_byte", {4'b1001, 8'h77});
    for (int i = 0; i < 6; i++) begin
      bus_if.MCU_SCK_EN = 1'b1; bus_if.MCU_MOSI = (i < 4); step();
    end
    check("pre_rst_6bits", {4'b1101, 8'h77});
    RESET = 1'b1; bus_if.SAMPLE_READY = 1'b1; bus_if.ERR_CLR = 1'b0; step();
    check("mid_reset", 12'h000);
    RESET = 1'b0; bus_if.SAMPLE_READY = 1'b0;
    bus_if.MCU_SCK_EN = 1'b0; bus_if.MCU_MOSI = 1'b0;
    send_byte(8'h9C);
    step();
    check("post_rst_byte", {4'b1000, 8'h9C});
    bus_if.SAMPLE_READY = 1'b1; step(); bus_if.SAMPLE_READY = 1'b0;
    check("post_rst_pop", {4'b0000, 8'h9C});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
